// File: rtl/sam_sdram_pkg.sv
// rtl/sam_sdram_pkg.sv - shared SDRAM misc-port constants, arbiter state type and helpers
package sam_sdram_pkg;

  localparam int SDRAM_AW = 25;

  // Last WAIT_HI cycle (counting from 0) before a missing busy response forces a re-edge.
  localparam logic [1:0] EDGE_WAIT_LAST = 2'd3;

  typedef enum logic [2:0] {
    RESYNC,
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    CAPTURE,
    RELEASE
  } arb_state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/sdram_misc_arbiter_if.sv
// rtl/sdram_misc_arbiter_if.sv - requester bus and controller misc port bundle for the arbiter
interface sdram_misc_arbiter_if
  import sam_sdram_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = SDRAM_AW
);

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_din;
  logic [N-1:0]    req_ack;
  logic [7:0]      rsp_dout;
  logic [AW-1:0]   misc_addr;
  logic [7:0]      misc_din;
  logic            misc_rd;
  logic            misc_we;
  logic            misc_busy;
  logic [7:0]      misc_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_din, misc_busy, misc_dout,
    output req_ack, rsp_dout, misc_addr, misc_din, misc_rd, misc_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_din, misc_busy, misc_dout,
    input  req_ack, rsp_dout, misc_addr, misc_din, misc_rd, misc_we
  );

endinterface

// File: rtl/sdram_misc_arbiter_rr_pick.sv
// rtl/sdram_misc_arbiter_rr_pick.sv - combinational round-robin picker with optional requester-0 priority
module rr_pick
  import sam_sdram_pkg::*;
#(
  parameter int N     = 4,
  parameter int PW    = (N > 1) ? $clog2(N) : 1,
  parameter bit PRIO0 = 1'b1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          any_o
);

  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic          found;
  logic [PW:0]   sum_w;
  logic [PW-1:0] idx_w;

  // Scan from ptr upward; the explicit subtract handles non-power-of-2 N.
  always_comb begin
    grant_o = '0;
    any_o   = |req_i;
    found   = 1'b0;
    sum_w   = '0;
    idx_w   = '0;
    if (PRIO0 && req_i[0]) begin
      grant_o[0] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        sum_w = {1'b0, ptr_i} + (PW+1)'(k);
        if (sum_w >= N_W) sum_w = sum_w - N_W;
        idx_w = sum_w[PW-1:0];
        if (!found && req_i[idx_w]) begin
          grant_o[idx_w] = 1'b1;
          found          = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_misc_arbiter.sv
// rtl/sdram_misc_arbiter.sv - shares the SDRAM controller's edge-triggered misc byte port between N requesters
module sdram_misc_arbiter
  import sam_sdram_pkg::*;
#(
  parameter int N     = 4,
  parameter int AW    = SDRAM_AW,
  parameter bit PRIO0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdram_misc_arbiter_if.slave  bus
);

  localparam int            PW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          cur_we_q, cur_we_d;
  logic          rd_q, rd_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    dout_q, dout_d;
  logic [1:0]    wait_q, wait_d;
  logic [1:0]    retry_q, retry_d;

  logic [N-1:0]  pick_grant;
  logic          pick_any;
  logic [PW-1:0] pick_idx;

  rr_pick #(
    .N     (N),
    .PW    (PW),
    .PRIO0 (PRIO0)
  ) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (pick_grant[k]) pick_idx = PW'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    cur_we_d = cur_we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dout_d   = dout_q;
    wait_d   = wait_q;
    retry_d  = retry_q;
    ack_d    = '0;
    rd_d     = 1'b0;
    we_d     = 1'b0;

    case (state_q)
      RESYNC: begin
        if (!bus.misc_busy) state_d = IDLE;
      end
      IDLE: begin
        // A busy controller here means it saw an edge we did not send; let it drain first.
        if (pick_any && !bus.misc_busy) begin
          grant_d  = pick_grant;
          gidx_d   = pick_idx;
          cur_we_d = bus.req_we[pick_idx];
          addr_d   = bus.req_addr[pick_idx*AW +: AW];
          din_d    = bus.req_din[pick_idx*8 +: 8];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        rd_d    = ~cur_we_q;
        we_d    = cur_we_q;
        wait_d  = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.misc_busy) begin
          rd_d    = rd_q;
          we_d    = we_q;
          state_d = WAIT_LO;
        end else if (wait_q == EDGE_WAIT_LAST) begin
          // Edge presumed lost: one low cycle in ISSUE, then a fresh rising edge.
          retry_d = sat_inc2(retry_q);
          state_d = ISSUE;
        end else begin
          rd_d   = rd_q;
          we_d   = we_q;
          wait_d = wait_q + 2'd1;
        end
      end
      WAIT_LO: begin
        if (bus.misc_busy) begin
          rd_d = rd_q;
          we_d = we_q;
        end else if (cur_we_q) begin
          ack_d   = grant_q;
          state_d = RELEASE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        dout_d  = bus.misc_dout;
        ack_d   = grant_q;
        state_d = RELEASE;
      end
      RELEASE: begin
        rr_ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = RESYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RESYNC;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      cur_we_q <= 1'b0;
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      ack_q    <= '0;
      wait_q   <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      cur_we_q <= cur_we_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      ack_q    <= ack_d;
      wait_q   <= wait_d;
      retry_q  <= retry_d;
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.rsp_dout  = dout_q;
  assign bus.misc_addr = addr_q;
  assign bus.misc_din  = din_q;
  assign bus.misc_rd   = rd_q;
  assign bus.misc_we   = we_q;

endmodule

// File: tb/tb_sdram_misc_arbiter.sv
// tb/tb_sdram_misc_arbiter.sv - directed bench: PRIO0=0 and PRIO0=1 arbiters, each on a behavioural controller
module tb_sdram_misc_arbiter;
  import sam_sdram_pkg::*;

  localparam int N  = 4;
  localparam int AW = SDRAM_AW;
  localparam int NI = 2;

  typedef struct {
    int             inst;
    int             idx;
    bit             we;
    logic [AW-1:0]  addr;
    logic [7:0]     din;
    logic [7:0]     exp_dout;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid [NI];
  logic [N-1:0]    req_we    [NI];
  logic [N*AW-1:0] req_addr  [NI];
  logic [N*8-1:0]  req_din   [NI];
  logic [N-1:0]    ack       [NI];
  logic [7:0]      rsp       [NI];
  logic            rd        [NI];
  logic            wr        [NI];
  logic [AW-1:0]   maddr     [NI];
  logic [7:0]      mdin      [NI];
  logic            busy      [NI];
  int              edges_a   [NI];
  int              rd_rise_a [NI];
  int              we_rise_a [NI];
  int              ign_a     [NI];
  int              ovl_a     [NI];
  logic [AW-1:0]   la_a      [NI];
  logic [7:0]      ld_a      [NI];
  logic            lop_a     [NI];
  int              ignore_at [NI];

  int checks = 0;
  int passes = 0;

  for (genvar j = 0; j < NI; j++) begin : g_inst
    sdram_misc_arbiter_if #(.N(N), .AW(AW)) bus ();

    sdram_misc_arbiter #(.N(N), .AW(AW), .PRIO0(j == 1)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus)
    );

    // Controller model: busy 1 cycle after an edge for 6 cycles, read data 1 cycle after busy falls.
    logic          busy_r  = 1'b0;
    logic [7:0]    dout_r  = 8'h00;
    int            cnt     = 0;
    logic          prev_rd = 1'b0;
    logic          prev_we = 1'b0;
    logic          dpend   = 1'b0;
    int            rise_cnt = 0;
    int            rd_rise  = 0;
    int            we_rise  = 0;
    int            ign_cnt  = 0;
    int            ovl_cnt  = 0;
    logic [AW-1:0] la  = '0;
    logic [7:0]    ld  = '0;
    logic          lop = 1'b0;
    logic          rd_up;
    logic          we_up;

    assign rd_up = bus.misc_rd & ~prev_rd;
    assign we_up = bus.misc_we & ~prev_we;

    always @(posedge clk) begin
      prev_rd <= bus.misc_rd;
      prev_we <= bus.misc_we;
      dpend   <= 1'b0;
      if (bus.misc_rd && bus.misc_we) ovl_cnt <= ovl_cnt + 1;
      if (dpend && !lop) dout_r <= la[7:0] ^ 8'hE0;
      if (rd_up || we_up) begin
        rise_cnt <= rise_cnt + 1;
        if (rd_up) rd_rise <= rd_rise + 1;
        if (we_up) we_rise <= we_rise + 1;
        if (rise_cnt == ignore_at[j]) begin
          ign_cnt <= ign_cnt + 1;
        end else if (cnt == 0) begin
          busy_r <= 1'b1;
          cnt    <= 6;
          la     <= bus.misc_addr;
          ld     <= bus.misc_din;
          lop    <= bus.misc_we;
        end
      end
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          busy_r <= 1'b0;
          dpend  <= 1'b1;
        end
      end
    end

    assign bus.req_valid = req_valid[j];
    assign bus.req_we    = req_we[j];
    assign bus.req_addr  = req_addr[j];
    assign bus.req_din   = req_din[j];
    assign bus.misc_busy = busy_r;
    assign bus.misc_dout = dout_r;
    assign ack[j]        = bus.req_ack;
    assign rsp[j]        = bus.rsp_dout;
    assign rd[j]         = bus.misc_rd;
    assign wr[j]         = bus.misc_we;
    assign maddr[j]      = bus.misc_addr;
    assign mdin[j]       = bus.misc_din;
    assign busy[j]       = busy_r;
    assign edges_a[j]    = rise_cnt;
    assign rd_rise_a[j]  = rd_rise;
    assign we_rise_a[j]  = we_rise;
    assign ign_a[j]      = ign_cnt;
    assign ovl_a[j]      = ovl_cnt;
    assign la_a[j]       = la;
    assign ld_a[j]       = ld;
    assign lop_a[j]      = lop;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ack(input int inst, input int budget, output int who);
    who = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ack[inst] != '0) begin
        for (int k = N - 1; k >= 0; k--) if (ack[inst][k]) who = k;
        return;
      end
    end
  endtask

  task automatic set_req(input int inst, input int idx, input bit we,
                         input logic [AW-1:0] addr, input logic [7:0] din);
    req_we[inst][idx]           = we;
    req_addr[inst][idx*AW +: AW] = addr;
    req_din[inst][idx*8 +: 8]    = din;
    req_valid[inst][idx]        = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   who, e0, r0, w0, i0, bad;
    int   order [5];

    vecs[0] = '{0, 2, 1'b0, 25'h0012345, 8'h00, 8'hA5};
    vecs[1] = '{0, 1, 1'b1, 25'h1FFFFFF, 8'h3C, 8'h00};
    vecs[2] = '{0, 0, 1'b0, 25'h0000000, 8'h00, 8'hE0};
    vecs[3] = '{0, 3, 1'b1, 25'h0000080, 8'hFF, 8'h00};
    vecs[4] = '{0, 3, 1'b0, 25'h1FFFF1F, 8'h00, 8'hFF};
    vecs[5] = '{1, 0, 1'b0, 25'h0ABCDEF, 8'h00, 8'h0F};
    vecs[6] = '{1, 2, 1'b1, 25'h0000001, 8'h00, 8'h00};
    order   = '{0, 1, 2, 3, 0};

    for (int i = 0; i < NI; i++) begin
      req_valid[i] = '0;
      req_we[i]    = '0;
      ignore_at[i] = -1;
      for (int s = 0; s < N; s++) begin
        req_addr[i][s*AW +: AW] = AW'($urandom());
        req_din[i][s*8 +: 8]    = 8'($urandom());
      end
    end

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ack", 32'(ack[0]), 0);
    chk("reset_rsp", 32'(rsp[0]), 0);
    chk("reset_rd", 32'(rd[0]), 0);
    chk("reset_we", 32'(wr[0]), 0);
    chk("reset_addr", 32'(maddr[0]), 0);
    chk("reset_din", 32'(mdin[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round-robin under full contention, PRIO0=0.
    e0 = edges_a[0];
    for (int i = 0; i < N; i++) set_req(0, i, 1'b0, AW'(32'h100 + i * 16), 8'h00);
    for (int n = 0; n < 5; n++) begin
      wait_ack(0, 40, who);
      chk($sformatf("rr_order%0d", n), 32'(who), 32'(order[n]));
      if (n == 4) req_valid[0] = '0;
    end
    chk("rr_edges", 32'(edges_a[0] - e0), 5);
    repeat (3) @(negedge clk);

    // PRIO0=1: requester 0 arrives mid-transfer of 1 and overtakes 3.
    e0 = edges_a[1];
    set_req(1, 1, 1'b0, 25'h0000011, 8'h00);
    set_req(1, 3, 1'b0, 25'h0000033, 8'h00);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (edges_a[1] != e0) break;
    end
    chk("prio_first_addr", 32'(la_a[1]), 32'h11);
    set_req(1, 0, 1'b0, 25'h0000022, 8'h00);
    wait_ack(1, 40, who);
    chk("prio_g1", 32'(who), 1);
    chk("prio_g1_dout", 32'(rsp[1]), 32'hF1);
    req_valid[1][1] = 1'b0;
    wait_ack(1, 40, who);
    chk("prio_g0", 32'(who), 0);
    chk("prio_g0_dout", 32'(rsp[1]), 32'hC2);
    req_valid[1][0] = 1'b0;
    wait_ack(1, 40, who);
    chk("prio_g3", 32'(who), 3);
    chk("prio_g3_dout", 32'(rsp[1]), 32'hD3);
    req_valid[1][3] = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      r0 = rd_rise_a[vecs[v].inst];
      w0 = we_rise_a[vecs[v].inst];
      set_req(vecs[v].inst, vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].din);
      wait_ack(vecs[v].inst, 40, who);
      req_valid[vecs[v].inst][vecs[v].idx] = 1'b0;
      chk($sformatf("v%0d_ack", v), 32'(who), 32'(vecs[v].idx));
      chk($sformatf("v%0d_addr", v), 32'(la_a[vecs[v].inst]), 32'(vecs[v].addr));
      chk($sformatf("v%0d_op", v), 32'(lop_a[vecs[v].inst]), 32'(vecs[v].we));
      chk($sformatf("v%0d_rd_edges", v), 32'(rd_rise_a[vecs[v].inst] - r0), vecs[v].we ? 0 : 1);
      chk($sformatf("v%0d_we_edges", v), 32'(we_rise_a[vecs[v].inst] - w0), vecs[v].we ? 1 : 0);
      if (vecs[v].we) chk($sformatf("v%0d_din", v), 32'(ld_a[vecs[v].inst]), 32'(vecs[v].din));
      else            chk($sformatf("v%0d_dout", v), 32'(rsp[vecs[v].inst]), 32'(vecs[v].exp_dout));
      repeat (2) @(negedge clk);
    end

    // Reset during WAIT_LO: interrupted ack is lost, arbiter resyncs on busy.
    set_req(0, 2, 1'b0, 25'h0000033, 8'h00);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy[0]) break;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd", 32'(rd[0]), 0);
    chk("rst_mid_we", 32'(wr[0]), 0);
    chk("rst_mid_ack", 32'(ack[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy_at_release", 32'(busy[0]), 1);
    bad = 0;
    for (int c = 0; c < 20 && busy[0]; c++) begin
      @(negedge clk);
      if (rd[0] || wr[0] || ack[0] != '0) bad++;
    end
    chk("rst_resync_quiet", 32'(bad), 0);
    wait_ack(0, 40, who);
    req_valid[0][2] = 1'b0;
    chk("rst_reissue_ack", 32'(who), 2);
    chk("rst_reissue_dout", 32'(rsp[0]), 32'hD3);
    repeat (3) @(negedge clk);

    // Lost edge: the model ignores the first write edge; one retry, one ack.
    e0 = edges_a[0];
    i0 = ign_a[0];
    w0 = we_rise_a[0];
    r0 = rd_rise_a[0];
    ignore_at[0] = edges_a[0];
    set_req(0, 1, 1'b1, 25'h0000777, 8'h5A);
    wait_ack(0, 60, who);
    req_valid[0][1] = 1'b0;
    ignore_at[0] = -1;
    chk("lost_ack", 32'(who), 1);
    chk("lost_edges", 32'(edges_a[0] - e0), 2);
    chk("lost_ignored", 32'(ign_a[0] - i0), 1);
    chk("lost_we_edges", 32'(we_rise_a[0] - w0), 2);
    chk("lost_rd_edges", 32'(rd_rise_a[0] - r0), 0);
    chk("lost_din", 32'(ld_a[0]), 32'h5A);
    wait_ack(0, 15, who);
    chk("lost_single_ack", 32'(who), 32'hFFFFFFFF);

    chk("overlap_inst0", 32'(ovl_a[0]), 0);
    chk("overlap_inst1", 32'(ovl_a[1]), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
